// File: rtl/fetch_unit_if.sv
// System-bus request/response channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic        respack;

    modport master (output reqcyc, req, reqtag, respack, input reqack, respcyc, resp);
    modport slave  (input reqcyc, req, reqtag, respack, output reqack, respcyc, resp);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: line requests, beat capture into a circular byte
// buffer, and a sliding decode window with redirect and entry-alignment handling.
module fetch_unit #(
    parameter int          BUF_BYTES        = 128,
    parameter int          WINDOW_BYTES     = 15,
    parameter int          REFILL_THRESHOLD = 32,
    parameter logic [12:0] REQ_TAG          = 13'h1100
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [63:0]                 entry,
    input  logic                        redirect,
    input  logic [63:0]                 redirect_rip,
    fetch_unit_if.master                bus,
    output logic                        dec_valid,
    output logic [8*WINDOW_BYTES-1:0]   dec_bytes,
    output logic [63:0]                 dec_rip,
    input  logic [3:0]                  dec_consume
);
    localparam int IW = $clog2(BUF_BYTES);
    localparam int PW = IW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RECV} state_t;

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occupancy;
    logic [63:0]   fetch_line;
    logic [2:0]    beat_cnt;
    logic [2:0]    skip_beats;
    logic [2:0]    skip_bytes;
    logic          discard;
    logic          reqcyc_r;
    logic [7:0]    buf_mem [BUF_BYTES];
    logic          beat;
    logic          last_beat;
    logic          keep;

    assign occupancy   = wr_ptr - rd_ptr;
    assign dec_valid   = occupancy >= PW'(WINDOW_BYTES);
    assign bus.reqcyc  = reqcyc_r;
    assign bus.req     = fetch_line;
    assign bus.reqtag  = REQ_TAG;
    assign bus.respack = bus.respcyc;

    assign beat      = (state == WAIT || state == RECV) && bus.respcyc;
    assign last_beat = beat && (beat_cnt == 3'd7);
    // Leading beats before the entry/redirect target are dropped on the first line only.
    assign keep      = beat && !redirect && !discard && (beat_cnt >= skip_beats);

    always_comb begin
        dec_bytes = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            dec_bytes[8*(WINDOW_BYTES-1-i) +: 8] = buf_mem[IW'(rd_ptr + PW'(i))];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            reqcyc_r   <= 1'b0;
            fetch_line <= entry & ~64'd63;
            dec_rip    <= entry;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= 3'd0;
            skip_beats <= entry[5:3];
            skip_bytes <= entry[2:0];
            discard    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqcyc_r && bus.reqack) begin
                        reqcyc_r <= 1'b0;
                        state    <= WAIT;
                    end else if (redirect) begin
                        reqcyc_r <= 1'b0;
                    end else if (occupancy < PW'(REFILL_THRESHOLD)) begin
                        reqcyc_r <= 1'b1;
                    end
                end
                default: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        state    <= last_beat ? IDLE : RECV;
                    end
                end
            endcase

            if (redirect) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                dec_rip    <= redirect_rip;
                fetch_line <= redirect_rip & ~64'd63;
                skip_beats <= redirect_rip[5:3];
                skip_bytes <= redirect_rip[2:0];
                // A line already accepted by the bus must still be drained before refetching.
                discard    <= ((state != IDLE) && !last_beat) ||
                              ((state == IDLE) && reqcyc_r && bus.reqack);
            end else begin
                dec_rip <= dec_rip + 64'(dec_consume);
                if (keep) begin
                    wr_ptr     <= wr_ptr + PW'(8);
                    rd_ptr     <= rd_ptr + PW'(dec_consume) + PW'(skip_bytes);
                    skip_bytes <= 3'd0;
                    skip_beats <= 3'd0;
                end else begin
                    rd_ptr <= rd_ptr + PW'(dec_consume);
                end
                if (last_beat) begin
                    discard <= 1'b0;
                    if (!discard) fetch_line <= fetch_line + 64'd64;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_BYTES; i++) buf_mem[i] <= 8'd0;
        end else if (keep) begin
            for (int b = 0; b < 8; b++) buf_mem[IW'(wr_ptr + PW'(b))] <= bus.resp[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        assert (reset || redirect || (PW'(dec_consume) <= occupancy))
            else $fatal(1, "dec_consume exceeds buffer occupancy");
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a request-address scoreboard and a byte-memory model.
module tb_fetch_unit;
    logic          clk;
    logic          reset;
    logic [63:0]   entry;
    logic          redirect;
    logic [63:0]   redirect_rip;
    logic          dec_valid;
    logic [119:0]  dec_bytes;
    logic [63:0]   dec_rip;
    logic [3:0]    dec_consume;

    int            compared = 0;
    int            mismatched = 0;
    logic [63:0]   exp_req [$];

    int            occ_m;
    logic [63:0]   rip_m;
    int            beats_left;
    logic [63:0]   cur_line;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .entry        (entry),
        .redirect     (redirect),
        .redirect_rip (redirect_rip),
        .bus          (bus),
        .dec_valid    (dec_valid),
        .dec_bytes    (dec_bytes),
        .dec_rip      (dec_rip),
        .dec_consume  (dec_consume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [63:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        logic [63:0] d;
        for (int b = 0; b < 8; b++) d[8*b +: 8] = mb(a + 64'(b));
        return d;
    endfunction

    function automatic logic [119:0] exp_win(input logic [63:0] a);
        logic [119:0] w;
        for (int i = 0; i < 15; i++) w[8*(14-i) +: 8] = mb(a + 64'(i));
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take_request(input string tag);
        int n;
        logic [63:0] e;
        n = 0;
        while (!bus.reqcyc && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_reqcyc"}, bus.reqcyc, 1'b1);
        e = (exp_req.size() > 0) ? exp_req.pop_front() : 64'hDEAD;
        check({tag, "_req"}, bus.req, e);
        check({tag, "_reqtag"}, bus.reqtag, 13'h1100);
        bus.reqack = 1'b1;
        tick();
        bus.reqack = 1'b0;
        check({tag, "_reqdrop"}, bus.reqcyc, 1'b0);
    endtask

    task automatic send_beat(input logic [63:0] line, input int k);
        bus.respcyc = 1'b1;
        bus.resp    = beat_data(line + 64'(8*k));
        #1;
        check("respack", bus.respack, 1'b1);
        tick();
        bus.respcyc = 1'b0;
        bus.resp    = '0;
    endtask

    initial begin
        int c;
        logic beat_now;
        bus.reqack   = 1'b0;
        bus.respcyc  = 1'b0;
        bus.resp     = '0;
        redirect     = 1'b0;
        redirect_rip = '0;
        dec_consume  = 4'd0;
        entry        = 64'h1000;
        reset        = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_reqcyc", bus.reqcyc, 1'b0);
        check("rst_req", bus.req, 64'h1000);
        check("rst_reqtag", bus.reqtag, 13'h1100);
        check("rst_valid", dec_valid, 1'b0);
        check("rst_bytes", dec_bytes, 120'd0);
        check("rst_rip", dec_rip, 64'h1000);

        // Startup at aligned entry
        reset = 1'b0;
        exp_req.push_back(64'h1000);
        take_request("start");
        send_beat(64'h1000, 0);
        check("start_valid_1beat", dec_valid, 1'b0);
        send_beat(64'h1000, 1);
        check("start_valid", dec_valid, 1'b1);
        check("start_bytes", dec_bytes, exp_win(64'h1000));
        check("start_rip", dec_rip, 64'h1000);
        for (int k = 2; k < 8; k++) send_beat(64'h1000, k);

        // Throttle: no request above the refill threshold
        dec_consume = 4'd15;
        tick();
        dec_consume = 4'd9;
        tick();
        dec_consume = 4'd0;
        check("thr_rip", dec_rip, 64'h1018);
        check("thr_bytes", dec_bytes, exp_win(64'h1018));
        tick(); tick(); tick();
        check("thr_noreq40", bus.reqcyc, 1'b0);
        dec_consume = 4'd9;
        tick();
        dec_consume = 4'd0;
        check("thr_noreq_yet", bus.reqcyc, 1'b0);
        tick();
        check("thr_reqcyc", bus.reqcyc, 1'b1);
        check("thr_req", bus.req, 64'h1040);
        tick(); tick();
        check("thr_hold", bus.reqcyc, 1'b1);
        exp_req.push_back(64'h1040);
        take_request("thr");

        // Wrap: consume 15/cycle while lines stream in
        occ_m = 31;
        rip_m = 64'h1021;
        beats_left = 8;
        cur_line = 64'h1040;
        for (int cyc = 0; cyc < 48; cyc++) begin
            check("wrap_valid", dec_valid, (occ_m >= 15));
            if (occ_m >= 15) begin
                check("wrap_bytes", dec_bytes, exp_win(rip_m));
                check("wrap_rip", dec_rip, rip_m);
            end
            c = (occ_m >= 15) ? 15 : 0;
            dec_consume = 4'(c);
            beat_now = 1'b0;
            if (beats_left > 0) begin
                bus.respcyc = 1'b1;
                bus.resp    = beat_data(cur_line + 64'(8*(8-beats_left)));
                beat_now    = 1'b1;
            end else if (bus.reqcyc) begin
                if (exp_req.size() == 0) begin
                    check("wrap_unexp_req", bus.reqcyc, 1'b0);
                    cur_line = bus.req;
                end else begin
                    cur_line = exp_req.pop_front();
                    check("wrap_req", bus.req, cur_line);
                end
                bus.reqack = 1'b1;
            end
            tick();
            if (bus.reqack) beats_left = 8;
            bus.respcyc = 1'b0;
            bus.reqack  = 1'b0;
            dec_consume = 4'd0;
            occ_m = occ_m + (beat_now ? 8 : 0) - c;
            rip_m = rip_m + 64'(c);
            if (beat_now) begin
                beats_left--;
                if (beats_left == 0) exp_req.push_back(cur_line + 64'd64);
            end
        end
        check("wrap_passed_128", (rip_m >= 64'h1080), 1'b1);

        // Misaligned entry
        exp_req.delete();
        entry = 64'h1013;
        reset = 1'b1;
        tick();
        tick();
        check("mis_rst_rip", dec_rip, 64'h1013);
        reset = 1'b0;
        exp_req.push_back(64'h1000);
        take_request("mis");
        for (int k = 0; k < 4; k++) send_beat(64'h1000, k);
        check("mis_valid_lo", dec_valid, 1'b0);
        send_beat(64'h1000, 4);
        check("mis_valid", dec_valid, 1'b1);
        check("mis_bytes", dec_bytes, exp_win(64'h1013));
        check("mis_rip", dec_rip, 64'h1013);
        for (int k = 5; k < 8; k++) send_beat(64'h1000, k);

        // Redirect during beat 3 of line 0x1040
        dec_consume = 4'd15;
        tick();
        dec_consume = 4'd0;
        exp_req.push_back(64'h1040);
        take_request("rdpre");
        for (int k = 0; k < 3; k++) send_beat(64'h1040, k);
        redirect     = 1'b1;
        redirect_rip = 64'h2008;
        send_beat(64'h1040, 3);
        redirect     = 1'b0;
        check("rd_valid", dec_valid, 1'b0);
        check("rd_rip", dec_rip, 64'h2008);
        for (int k = 4; k < 8; k++) begin
            send_beat(64'h1040, k);
            check("rd_discard_noreq", bus.reqcyc, 1'b0);
            check("rd_discard_valid", dec_valid, 1'b0);
        end
        exp_req.push_back(64'h2000);
        take_request("rd");
        send_beat(64'h2000, 0);
        send_beat(64'h2000, 1);
        check("rd_valid_8", dec_valid, 1'b0);
        send_beat(64'h2000, 2);
        check("rd_new_valid", dec_valid, 1'b1);
        check("rd_new_bytes", dec_bytes, exp_win(64'h2008));
        check("rd_new_rip", dec_rip, 64'h2008);

        // Asynchronous reset mid-line
        send_beat(64'h2000, 3);
        send_beat(64'h2000, 4);
        entry = 64'h3456;
        reset = 1'b1;
        #1;
        check("areset_reqcyc", bus.reqcyc, 1'b0);
        check("areset_valid", dec_valid, 1'b0);
        check("areset_rip", dec_rip, 64'h3456);
        check("areset_req", bus.req, 64'h3440);
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
